span_capture: RTL
=================

SPAN_CAPTURE -- requirements
Module: span_capture

Interface
REQ-001 The block SHALL use reset reset, asynchronous, active-high; clock clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 pin_x  input  8  pixel x coordinate, sampled when pin_v=1.
REQ-005 pin_y  input  8  pixel y coordinate, sampled when pin_v=1.
REQ-006 pin_v  input  1  pixel valid: one pixel per cycle while high.
REQ-007 rd_en  input  1  pop request for the head span record.
REQ-008 span_valid  output  1  span FIFO non-empty; span_* fields show the head record (first-word-fall-through).
REQ-009 span_y  output  8  head record y.
REQ-010 span_xl  output  8  head record leftmost x.
REQ-011 span_xr  output  8  head record rightmost x.
REQ-012 span_cnt  output  3  FIFO occupancy, 0..4.
REQ-013 overflow  output  1  sticky: a record was dropped because the FIFO was full.
REQ-014 err_gap  output  1  present only with SPAN_GAP_CHK_EN (see Configuration).

Function
REQ-015 Two-state FSM, IDLE and RUN; current span held in registers cur_y, cur_xl, cur_xr.
REQ-016 IDLE with pin_v=1: load cur_y=pin_y, cur_xl=cur_xr=pin_x; go to RUN.
REQ-017 RUN with pin_v=1, pin_y==cur_y, pin_x==cur_xr+1 (8-bit, no wrap match: cur_xr=255 never extends): cur_xr<=pin_x; stay in RUN.
REQ-018 RUN with pin_v=1, pin_y==cur_y, pin_x==cur_xr: duplicate pixel, no state change.
REQ-019 RUN with pin_v=1 and any other (x,y): push {cur_y,cur_xl,cur_xr}, open a new span from the sampled pixel in the same cycle; stay in RUN.
REQ-020 RUN with pin_v=0: push current span; go to IDLE.
REQ-021 A pushed record SHALL be visible on span_valid/span_* in the cycle after the push edge (1-cycle latency).
REQ-022 FIFO depth 4 records of 24 bits; in-order delivery.
REQ-023 rd_en=1 with span_valid=1 pops the head on that edge; rd_en with empty FIFO SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL both take effect, including when full (span_cnt stays 4, no drop).
REQ-025 Push when full without pop: record discarded, FIFO unchanged, overflow<=1 and held until reset.
REQ-026 Single-pixel span (pin_v high one cycle) SHALL produce a record with xl==xr.

Reset
REQ-027 reset SHALL force: state IDLE, FIFO empty, span_valid=0, span_cnt=0, span_y/span_xl/span_xr=0, overflow=0, err_gap=0, cur_* =0.
REQ-028 reset mid-span SHALL discard the open span and all queued records; no partial record is emitted after reset release.

Configuration
REQ-029 Macro SPAN_GAP_CHK_EN defined: err_gap port exists; err_gap pulses 1 for exactly one cycle, the cycle after a REQ-019 push caused by pin_y==cur_y with pin_x not in {cur_xr, cur_xr+1}.
REQ-030 SPAN_GAP_CHK_EN undefined: err_gap port and its logic absent; all other behaviour identical.

Verification
REQ-031 Pixels y=10, x=5..9 on 5 consecutive cycles then pin_v=0 -> one record {10,5,9}, span_valid=1 one cycle after pin_v falls, span_cnt=1.
REQ-032 Single pixel y=3,x=200 then idle -> record {3,200,200}.
REQ-033 Stream y=7 x=20,21 then y=8 x=20,21 back-to-back, then idle -> records {7,20,21} then {8,20,21}; err_gap stays 0.
REQ-034 Five spans pushed, rd_en=0 -> span_cnt=4, overflow=1, fifth record lost; then pop while pushing a sixth at full -> span_cnt stays 4, no new overflow event.
REQ-035 y=1 x=254,255,0 -> records {1,254,255} and {1,0,0}; with SPAN_GAP_CHK_EN err_gap pulses once.
REQ-036 Assert reset during span y=4 x=50..52 after x=51 -> after release span_valid=0, span_cnt=0, overflow=0, no record for y=4.

Source files
------------

// File: rtl/span_capture_if.sv
// span_capture_if: pixel input, span FIFO read side and status.
// Ports: master drives pin_*/rd_en; slave drives span_*/overflow/err_gap.
`timescale 1ns/1ps
interface span_capture_if;
  logic [7:0] pin_x;
  logic [7:0] pin_y;
  logic       pin_v;
  logic       rd_en;
  logic       span_valid;
  logic [7:0] span_y;
  logic [7:0] span_xl;
  logic [7:0] span_xr;
  logic [2:0] span_cnt;
  logic       overflow;
`ifdef SPAN_GAP_CHK_EN
  logic       err_gap;
`endif

  modport master (
    output pin_x, pin_y, pin_v, rd_en,
    input  span_valid, span_y, span_xl,
    input  span_xr, span_cnt, overflow
`ifdef SPAN_GAP_CHK_EN
    , input err_gap
`endif
  );

  modport slave (
    input  pin_x, pin_y, pin_v, rd_en,
    output span_valid, span_y, span_xl,
    output span_xr, span_cnt, overflow
`ifdef SPAN_GAP_CHK_EN
    , output err_gap
`endif
  );
endinterface

// File: rtl/span_capture.sv
// span_capture: merges runs of x-adjacent pixels on one row into
// {y,xl,xr} span records queued in a 4-deep first-word-fall-through FIFO.
// Ports: clk, reset (async, active-high), bus (span_capture_if.slave).
// Macro SPAN_GAP_CHK_EN adds err_gap: one-cycle pulse on a same-row gap.
`timescale 1ns/1ps
module span_capture (
  input logic           clk,
  input logic           reset,
  span_capture_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cur_y_q, cur_y_d;
  logic [7:0]  cur_xl_q, cur_xl_d;
  logic [7:0]  cur_xr_q, cur_xr_d;
  logic [23:0] mem_q [4];
  logic [23:0] mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  logic        same_y, ext, dup;
  logic        push, pop, wr;
  logic [23:0] push_rec;

  assign same_y = bus.pin_y == cur_y_q;
  // x=255 can never be extended: no wrap to 0
  assign ext = same_y && (cur_xr_q != 8'hff) &&
               (bus.pin_x == cur_xr_q + 8'd1);
  assign dup = same_y && (bus.pin_x == cur_xr_q);
  assign push_rec = {cur_y_q, cur_xl_q, cur_xr_q};

  always_comb begin
    state_d  = state_q;
    cur_y_d  = cur_y_q;
    cur_xl_d = cur_xl_q;
    cur_xr_d = cur_xr_q;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.pin_v) begin
          cur_y_d  = bus.pin_y;
          cur_xl_d = bus.pin_x;
          cur_xr_d = bus.pin_x;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!bus.pin_v) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (ext) begin
          cur_xr_d = bus.pin_x;
        end else if (!dup) begin
          push     = 1'b1;
          cur_y_d  = bus.pin_y;
          cur_xl_d = bus.pin_x;
          cur_xr_d = bus.pin_x;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a pop frees the slot, so push at full still lands when popping
  assign pop = bus.rd_en && (cnt_q != 3'd0);
  assign wr  = push && ((cnt_q != 3'd4) || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr) begin
      mem_d[wr_ptr_q] = push_rec;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push && !wr) ovf_d = 1'b1;
    cnt_d = cnt_q + {2'b00, wr} - {2'b00, pop};
  end

`ifdef SPAN_GAP_CHK_EN
  logic err_q, err_d;
  always_comb begin
    err_d = (state_q == RUN) && bus.pin_v &&
            same_y && !ext && !dup;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign bus.err_gap = err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_y_q  <= '0;
      cur_xl_q <= '0;
      cur_xr_q <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_y_q  <= cur_y_d;
      cur_xl_q <= cur_xl_d;
      cur_xr_q <= cur_xr_d;
      for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // fields read zero when empty so reset/empty state is clean
  logic [23:0] head;
  assign head           = (cnt_q != 3'd0) ? mem_q[rd_ptr_q] : 24'd0;
  assign bus.span_valid = cnt_q != 3'd0;
  assign bus.span_y     = head[23:16];
  assign bus.span_xl    = head[15:8];
  assign bus.span_xr    = head[7:0];
  assign bus.span_cnt   = cnt_q;
  assign bus.overflow   = ovf_q;

endmodule
